mult_seq_ctrl: RTL

Sequential shift-add multiplier controller for unsigned M x N multiplication. It sequences a single M-bit adder over N clock cycles instead of instantiating the full N-row adder array, which trades area for latency. It sits beside the combinational array multiplier in the arithmetic datapath and uses a start/busy/done handshake with the surrounding control logic. The final product is registered and held until the next operation completes.

---
 rtl/mult_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Sequential shift-add multiplier for unsigned M x N operands. A single
// (M+1)-bit adder is reused for N iterations. Each iteration does two things:
//   - it conditionally adds the captured multiplicand into the high half of
//     the accumulator;
//   - it shifts the whole accumulator right by one bit.
// Surrounding control logic talks to the block through a start/busy/done
// handshake. The finished product is kept in its own register. That register
// holds its value until the next operation completes, so it stays stable
// through the following run.
//
// Parameters
//   M      width of multiplicand a (M >= 2)
//   N      width of multiplier b and number of iterations (N >= 2)
//
// Ports
//   clk    rising-edge clock, the only clock
//   rst    asynchronous, active-high reset
//   start  request a new multiplication; honoured only in IDLE or DONE
//   a      unsigned multiplicand, captured on the accepting edge
//   b      unsigned multiplier, captured on the accepting edge
//   busy   high while the iteration sequence is running
//   done   one-cycle pulse in the cycle that prod holds a fresh result
//   prod   registered product a*b, M+N bits
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [M+N-1:0] prod
);

    // Iteration counter width. N >= 2 guarantees at least two bits.
    localparam int CNT_W = $clog2(N + 1);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value during the final (Nth) iteration
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [M-1:0]     ra_q,    ra_d;      // captured multiplicand
    logic             c_q,     c_d;       // accumulator carry bit
    logic [M-1:0]     hi_q,    hi_d;      // accumulator high half
    logic [N-1:0]     lo_q,    lo_d;      // accumulator low half / multiplier
    logic [CNT_W-1:0] cnt_q,   cnt_d;     // completed iterations
    logic [M+N-1:0]   prod_q,  prod_d;    // result register
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Combinational helpers
    logic [M:0]       addend_s;           // multiplicand gated by current multiplier LSB
    logic [M:0]       sum_s;              // (M+1)-bit partial sum, never overflows
    logic             accept_s;           // new operation is taken on this edge

    // Partial-sum adder. The carry bit c sits directly above hi, so {c, hi}
    // is the (M+1)-bit addend. After every shift c is zero again, and the
    // adder's carry-out always lands in hi's MSB. No bit is ever lost.
    always_comb begin
        addend_s = {(M+1){1'b0}};
        if (lo_q[0]) begin
            addend_s = {1'b0, ra_q};
        end else begin
            addend_s = {(M+1){1'b0}};
        end
        sum_s = {c_q, hi_q} + addend_s;
    end

    // A start is honoured only when no iteration is in flight
    always_comb begin
        accept_s = 1'b0;
        if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state, datapath and output-register computation
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        c_d     = c_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    // Capture operands. The multiplier is shifted out of lo
                    // as the product is shifted in from the top.
                    ra_d    = a;
                    c_d     = 1'b0;
                    hi_d    = {M{1'b0}};
                    lo_d    = b;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // acc <= {1'b0, sum, lo} >> 1. Only the low M+N+1 bits are
                // kept. That leaves c = 0, hi = sum[M:1], and
                // lo = {sum[0], lo[N-1:1]}.
                c_d   = 1'b0;
                hi_d  = sum_s[M:1];
                lo_d  = {sum_s[0], lo_q[N-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Post-shift {hi, lo} is the finished product
                    prod_d  = {sum_s, lo_q[N-1:1]};
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                // Unreachable encoding: fall back to IDLE without
                // touching the held result.
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered from the next state. Their timing
        // matches a decode of state, but there is no decode logic on the
        // output pins.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= {M{1'b0}};
            c_q     <= 1'b0;
            hi_q    <= {M{1'b0}};
            lo_q    <= {N{1'b0}};
            cnt_q   <= CNT_ZERO;
            prod_q  <= {(M+N){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            c_q     <= c_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

endmodule
